pc_branch_unit: RTL and testbench

- Program-counter and branch-resolution stage that sits directly downstream of the ALU in the single-cycle datapath.
- Latches the ALU carry/zero/sign outputs into a flags register.
- Evaluates branch conditions against the registered flags, computes the next PC and drives the link value for calls.
- Provides a HALT state that freezes the PC until reset.

---
 rtl/pc_branch_unit.sv | 124 ++++++++++++
 tb/tb_pc_branch_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - PC register, flag latch and branch resolution
// The branch decision uses only the registered flags, so a same-cycle flag write is seen one instruction later.
module pc_branch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flag_we,
  input  logic             carry_in,
  input  logic             zero_in,
  input  logic             sign_in,
  input  logic [3:0]       branch_op,
  input  logic [21:0]      imm,
  input  logic [31:0]      reg_target,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             taken,
  output logic             link_we,
  output logic             carry_q,
  output logic             zero_q,
  output logic             sign_q,
  output logic             halted,
  output logic [CNT_W-1:0] br_count
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  localparam logic [3:0] OP_BR   = 4'b0001;
  localparam logic [3:0] OP_BLTZ = 4'b0010;
  localparam logic [3:0] OP_BZ   = 4'b0011;
  localparam logic [3:0] OP_BNZ  = 4'b0100;
  localparam logic [3:0] OP_BL   = 4'b0101;
  localparam logic [3:0] OP_BCY  = 4'b0110;
  localparam logic [3:0] OP_BNCY = 4'b0111;
  localparam logic [3:0] OP_JR   = 4'b1000;
  localparam logic [3:0] OP_HALT = 4'b1111;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] rel_target;
  logic [31:0] target;
  logic        cond;
  logic        is_link;
  logic        active;

  assign pc_plus4   = pc + 32'd4;
  // Word offset: sign-extend the 22-bit immediate and scale by 4 in one concatenation.
  assign rel_target = pc_plus4 + {{8{imm[21]}}, imm, 2'b00};
  assign active     = en && (state == S_RUN);
  assign halted     = (state == S_HALT);
  assign taken      = active && cond;
  assign link_we    = active && is_link;

  always_comb begin
    cond    = 1'b0;
    is_link = 1'b0;
    target  = rel_target;
    unique case (branch_op)
      OP_BR:   cond = 1'b1;
      OP_BLTZ: cond = sign_q;
      OP_BZ:   cond = zero_q;
      OP_BNZ:  cond = !zero_q;
      OP_BL: begin
        cond    = 1'b1;
        is_link = 1'b1;
      end
      OP_BCY:  cond = carry_q;
      OP_BNCY: cond = !carry_q;
      OP_JR: begin
        cond   = 1'b1;
        target = {reg_target[31:2], 2'b00};
      end
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    if (active) begin
      pc_nxt = taken ? target : pc_plus4;
      if (branch_op == OP_HALT) begin
        state_nxt = S_HALT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      sign_q  <= 1'b0;
    end else if (flag_we) begin
      carry_q <= carry_in;
      zero_q  <= zero_in;
      sign_q  <= sign_in;
    end
  end

  // Counter sticks at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count <= '0;
    end else if (taken && (br_count != {CNT_W{1'b1}})) begin
      br_count <= br_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// tb/tb_pc_branch_unit.sv - self-checking bench for pc_branch_unit
module tb_pc_branch_unit;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        flag_we = 1'b0;
  logic        carry_in = 1'b0;
  logic        zero_in = 1'b0;
  logic        sign_in = 1'b0;
  logic [3:0]  branch_op = 4'h0;
  logic [21:0] imm = 22'h0;
  logic [31:0] reg_target = 32'h0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        taken;
  logic        link_we;
  logic        carry_q;
  logic        zero_q;
  logic        sign_q;
  logic        halted;
  logic [CNT_W-1:0] br_count;

  pc_branch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .flag_we(flag_we),
    .carry_in(carry_in), .zero_in(zero_in), .sign_in(sign_in),
    .branch_op(branch_op), .imm(imm), .reg_target(reg_target),
    .pc(pc), .pc_plus4(pc_plus4), .taken(taken), .link_we(link_we),
    .carry_q(carry_q), .zero_q(zero_q), .sign_q(sign_q),
    .halted(halted), .br_count(br_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] m_pc = 32'h0;
  logic        m_c = 1'b0, m_z = 1'b0, m_s = 1'b0, m_halt = 1'b0;
  int          m_cnt = 0;
  bit          chk_en = 1'b0;

  function automatic logic m_taken();
    if (!en || m_halt) return 1'b0;
    case (branch_op)
      4'd1, 4'd5, 4'd8: return 1'b1;
      4'd2: return m_s;
      4'd3: return m_z;
      4'd4: return !m_z;
      4'd6: return m_c;
      4'd7: return !m_c;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_next();
    int off;
    off = int'($signed(imm)) * 4;
    if (!en || m_halt) return m_pc;
    if (!m_taken()) return m_pc + 32'd4;
    if (branch_op == 4'd8) return reg_target & ~32'd3;
    return m_pc + 32'd4 + off;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pc   <= 32'h0;
      m_c    <= 1'b0;
      m_z    <= 1'b0;
      m_s    <= 1'b0;
      m_halt <= 1'b0;
      m_cnt  <= 0;
      chk_en <= 1'b1;
    end else begin
      if (flag_we) begin
        m_c <= carry_in;
        m_z <= zero_in;
        m_s <= sign_in;
      end
      m_pc <= m_next();
      if (m_taken() && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
      if (en && !m_halt && branch_op == 4'hF) m_halt <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", pc, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("taken", {31'b0, taken}, {31'b0, m_taken()});
      chk("link_we", {31'b0, link_we}, {31'b0, en && !m_halt && branch_op == 4'd5});
      chk("flags", {29'b0, carry_q, zero_q, sign_q}, {29'b0, m_c, m_z, m_s});
      chk("halted", {31'b0, halted}, {31'b0, m_halt});
      chk("br_count", {28'b0, br_count}, 32'(m_cnt));
    end
  end

  task automatic set(input logic e, input logic [3:0] op, input logic [21:0] im,
                     input logic [31:0] rt, input logic fwe,
                     input logic c, input logic z, input logic s);
    en = e; branch_op = op; imm = im; reg_target = rt;
    flag_we = fwe; carry_in = c; zero_in = z; sign_in = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_flags", {29'b0, carry_q, zero_q, sign_q}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_cnt", {28'b0, br_count}, 32'h0);

    rst = 1'b0;
    set(1, 4'h0, 0, 0, 0, 0, 0, 0);
    tick(); chk("seq_pc1", pc, 32'h4);
    tick(); chk("seq_pc2", pc, 32'h8);
    tick(); chk("seq_pc3", pc, 32'hC);
    tick(); chk("seq_pc4", pc, 32'h10);

    set(1, 4'h3, 22'd5, 0, 1, 0, 1, 0);
    #1 chk("bz_hazard_taken", {31'b0, taken}, 32'h0);
    tick(); chk("bz_hazard_pc", pc, 32'h14);
    chk("bz_zero_q", {31'b0, zero_q}, 32'h1);
    set(1, 4'h3, 22'd5, 0, 0, 0, 0, 0);
    #1 chk("bz_taken", {31'b0, taken}, 32'h1);
    tick(); chk("bz_pc", pc, 32'h2C);
    chk("bz_cnt", {28'b0, br_count}, 32'h1);

    set(1, 4'h8, 0, 32'h43, 0, 0, 0, 0);
    tick(); chk("jr_to_40", pc, 32'h40);
    set(1, 4'h5, 22'h3FFFF0, 0, 0, 0, 0, 0);
    #1 chk("bl_link", {31'b0, link_we}, 32'h1);
    chk("bl_plus4", pc_plus4, 32'h44);
    tick(); chk("bl_pc", pc, 32'h4);

    set(0, 4'h0, 0, 0, 1, 0, 0, 1);
    tick(); chk("stall_flag_pc", pc, 32'h4);
    chk("sign_q", {31'b0, sign_q}, 32'h1);
    set(1, 4'h2, 22'h3FFFFE, 0, 0, 0, 0, 0);
    tick(); chk("bltz_pc", pc, 32'h0);

    set(1, 4'h8, 0, 32'h1237, 0, 0, 0, 0);
    tick(); chk("jr_align", pc, 32'h1234);
    set(1, 4'h8, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
    tick(); chk("jr_top", pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    set(1, 4'h0, 0, 0, 0, 0, 0, 0);
    tick(); chk("wrap_pc", pc, 32'h0);

    set(0, 4'h0, 0, 0, 1, 1, 0, 0);
    tick();
    set(1, 4'h6, 22'd3, 0, 0, 0, 0, 0);
    tick(); chk("bcy_pc", pc, 32'h10);
    set(1, 4'h7, 22'd3, 0, 0, 0, 0, 0);
    tick(); chk("bncy_pc", pc, 32'h14);
    set(1, 4'h4, 22'd0, 0, 0, 0, 0, 0);
    tick(); chk("bnz_pc", pc, 32'h18);
    set(1, 4'hA, 22'd7, 0, 0, 0, 0, 0);
    tick(); chk("undef_op_pc", pc, 32'h1C);
    chk("cnt_8", {28'b0, br_count}, 32'h8);

    set(0, 4'h1, 22'd9, 0, 0, 0, 0, 0);
    #1 chk("stall_taken", {31'b0, taken}, 32'h0);
    tick(); tick();
    chk("stall_pc", pc, 32'h1C);
    chk("stall_cnt", {28'b0, br_count}, 32'h8);

    set(1, 4'h0, 0, 0, 0, 0, 0, 0);
    tick();
    set(1, 4'hF, 0, 0, 0, 0, 0, 0);
    #1 chk("halt_taken", {31'b0, taken}, 32'h0);
    tick(); chk("halt_pc", pc, 32'h24);
    chk("halt_flag", {31'b0, halted}, 32'h1);
    set(1, 4'h1, 22'd9, 0, 0, 0, 0, 0);
    #1 chk("halted_taken", {31'b0, taken}, 32'h0);
    tick(); tick();
    chk("halted_pc", pc, 32'h24);
    chk("halted_cnt", {28'b0, br_count}, 32'h8);

    rst = 1'b1;
    set(1, 4'h1, 0, 0, 1, 1, 1, 1);
    tick();
    chk("rerst_pc", pc, 32'h0);
    chk("rerst_halted", {31'b0, halted}, 32'h0);
    chk("rerst_flags", {29'b0, carry_q, zero_q, sign_q}, 32'h0);
    chk("rerst_cnt", {28'b0, br_count}, 32'h0);

    rst = 1'b0;
    set(1, 4'h1, 0, 0, 0, 0, 0, 0);
    repeat (17) tick();
    chk("sat_cnt", {28'b0, br_count}, 32'hF);
    chk("sat_pc", pc, 32'h44);

    set(1, 4'h0, 0, 0, 0, 0, 0, 0);
    tick();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
